// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART types and helpers, used by the TX stream block and the future
// RX path.
//   parity_mode_t : line parity selection (none / even / odd)
//   tx_state_t    : transmitter frame state
//   MIN_DATA_BITS : smallest legal data field width
//   decode_parity : maps the raw 2-bit parity_mode control onto parity_mode_t
//   calc_parity   : parity bit over the low nbits bits of a data word
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int MIN_DATA_BITS = 5;
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_mode_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Encoding 2'b11 is reserved and behaves as "no parity".
    function automatic parity_mode_t decode_parity(input logic [1:0] mode);
        parity_mode_t res;
        case (mode)
            2'b01:   res = PAR_EVEN;
            2'b10:   res = PAR_ODD;
            default: res = PAR_NONE;
        endcase
        return res;
    endfunction

    // Even parity is the XOR of the transmitted bits; odd is its inverse.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input logic [3:0]               nbits,
                                         input parity_mode_t             mode);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (i < int'(nbits)) begin
                acc = acc ^ data[i];
            end
        end
        return (mode == PAR_ODD) ? ~acc : acc;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a separate occupancy counter so that full and empty
// are unambiguous when the pointers coincide. The head word is presented
// combinationally on rdata (first-word fall-through).
//   clk, nrst : clock, asynchronous active-low reset
//   push      : write wdata (ignored when full)
//   pop       : drop the head word (ignored when empty)
//   wdata     : write data
//   rdata     : current head word
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : words stored
// DEPTH must be a power of two, >= 2, so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (count_r == CNT_W'(DEPTH));
    assign empty  = (count_r == CNT_W'(0));
    assign count  = count_r;
    assign rdata  = mem_r[rd_ptr_r];
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;

    // Storage array; contents need no reset because count_r gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves count alone.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_stream.sv
// -----------------------------------------------------------------------------
// uart_tx_stream
// UART transmitter fed through a TX FIFO with a valid/ready write handshake.
// Frame format (bit period, data width, parity, stop bits) is sampled when a
// frame starts, so reconfiguring mid-frame only affects the following frame.
// Queued words stream back to back with no idle gap between frames.
//   clk, nrst   : clock, asynchronous active-low reset (aborts any frame)
//   bit_period  : clk cycles per bit, 0 behaves as 1
//   data_bits   : data bits per frame, 5..DATA_W, anything else means DATA_W
//   parity_mode : 00 none, 01 even, 10 odd, 11 none
//   two_stop    : 1 selects two stop bits
//   in_data     : word to send (payload in the LSBs)
//   in_valid    : producer has a word
//   in_ready    : FIFO has room
//   serial_out  : TX line, idle high
//   busy        : frame in flight or words queued
//   tx_done     : one-cycle pulse on the last cycle of each frame
//   fifo_count  : words queued, excluding the one being sent
// -----------------------------------------------------------------------------
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int BAUD_W     = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [BAUD_W-1:0] bit_period,
    input  logic [3:0]        data_bits,
    input  logic [1:0]        parity_mode,
    input  logic              two_stop,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              serial_out,
    output logic              busy,
    output logic              tx_done,
    output logic [CNT_W-1:0]  fifo_count
);

    // FIFO interface
    logic [DATA_W-1:0]        fifo_rdata_s;
    logic                     fifo_full_s;
    logic                     fifo_empty_s;
    logic [CNT_W-1:0]         fifo_count_s;
    logic                     pop_s;

    // Decoded configuration for a frame that starts on the next edge
    logic [BAUD_W-1:0]        eff_period_s;
    logic [3:0]               eff_bits_s;
    parity_mode_t             mode_s;
    logic [MAX_DATA_BITS-1:0] head_ext_s;
    logic                     head_par_s;
    logic                     frame_end_s;
    logic                     per_one_s;

    // Frame state
    tx_state_t                state_r;
    logic [BAUD_W-1:0]        cnt_r;
    logic [BAUD_W-1:0]        per_r;
    logic [DATA_W-1:0]        shift_r;
    logic [3:0]               nbits_r;
    logic [3:0]               bits_left_r;
    logic                     par_en_r;
    logic                     par_bit_r;
    logic                     two_stop_r;
    logic                     stop_left_r;
    logic                     serial_out_r;
    logic                     tx_done_r;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (in_valid),
        .pop   (pop_s),
        .wdata (in_data),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Full blocks writes even when a pop happens on the same edge.
    assign in_ready   = !fifo_full_s;
    assign fifo_count = fifo_count_s;
    assign serial_out = serial_out_r;
    assign tx_done    = tx_done_r;
    assign busy       = (state_r != IDLE) || (fifo_count_s != CNT_W'(0));

    // Last cycle of the last stop bit: the edge that closes the frame.
    assign frame_end_s = (state_r == STOP) && (cnt_r == BAUD_W'(0)) && !stop_left_r;
    assign pop_s       = !fifo_empty_s && ((state_r == IDLE) || frame_end_s);
    assign per_one_s   = (per_r == BAUD_W'(1));

    // Decode live configuration and the head word's parity for the next frame.
    always_comb begin
        if (bit_period == BAUD_W'(0)) begin
            eff_period_s = BAUD_W'(1);
        end else begin
            eff_period_s = bit_period;
        end
        if ((data_bits >= 4'(MIN_DATA_BITS)) && (data_bits <= 4'(DATA_W))) begin
            eff_bits_s = data_bits;
        end else begin
            eff_bits_s = 4'(DATA_W);
        end
        mode_s                   = decode_parity(parity_mode);
        head_ext_s               = '0;
        head_ext_s[DATA_W-1:0]   = fifo_rdata_s;
        head_par_s               = calc_parity(head_ext_s, eff_bits_s, mode_s);
    end

    // Frame FSM with bit down-counter, shift register and registered line outputs.
    // tx_done is raised one edge early so that it is high during the final
    // stop-bit cycle itself.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r      <= IDLE;
            cnt_r        <= BAUD_W'(0);
            per_r        <= BAUD_W'(1);
            shift_r      <= DATA_W'(0);
            nbits_r      <= 4'(DATA_W);
            bits_left_r  <= 4'd0;
            par_en_r     <= 1'b0;
            par_bit_r    <= 1'b0;
            two_stop_r   <= 1'b0;
            stop_left_r  <= 1'b0;
            serial_out_r <= 1'b1;
            tx_done_r    <= 1'b0;
        end else begin
            tx_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    serial_out_r <= 1'b1;
                    if (pop_s) begin
                        shift_r      <= fifo_rdata_s;
                        per_r        <= eff_period_s;
                        nbits_r      <= eff_bits_s;
                        par_en_r     <= (mode_s != PAR_NONE);
                        par_bit_r    <= head_par_s;
                        two_stop_r   <= two_stop;
                        cnt_r        <= eff_period_s - BAUD_W'(1);
                        serial_out_r <= 1'b0;
                        state_r      <= START;
                    end
                end
                START: begin
                    if (cnt_r == BAUD_W'(0)) begin
                        serial_out_r <= shift_r[0];
                        shift_r      <= {1'b0, shift_r[DATA_W-1:1]};
                        bits_left_r  <= nbits_r - 4'd1;
                        cnt_r        <= per_r - BAUD_W'(1);
                        state_r      <= DATA;
                    end else begin
                        cnt_r <= cnt_r - BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_r == BAUD_W'(0)) begin
                        cnt_r <= per_r - BAUD_W'(1);
                        if (bits_left_r != 4'd0) begin
                            serial_out_r <= shift_r[0];
                            shift_r      <= {1'b0, shift_r[DATA_W-1:1]};
                            bits_left_r  <= bits_left_r - 4'd1;
                        end else if (par_en_r) begin
                            serial_out_r <= par_bit_r;
                            state_r      <= PARITY;
                        end else begin
                            serial_out_r <= 1'b1;
                            stop_left_r  <= two_stop_r;
                            tx_done_r    <= !two_stop_r && per_one_s;
                            state_r      <= STOP;
                        end
                    end else begin
                        cnt_r <= cnt_r - BAUD_W'(1);
                    end
                end
                PARITY: begin
                    if (cnt_r == BAUD_W'(0)) begin
                        serial_out_r <= 1'b1;
                        stop_left_r  <= two_stop_r;
                        tx_done_r    <= !two_stop_r && per_one_s;
                        cnt_r        <= per_r - BAUD_W'(1);
                        state_r      <= STOP;
                    end else begin
                        cnt_r <= cnt_r - BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_r != BAUD_W'(0)) begin
                        cnt_r     <= cnt_r - BAUD_W'(1);
                        tx_done_r <= (cnt_r == BAUD_W'(1)) && !stop_left_r;
                    end else if (stop_left_r) begin
                        stop_left_r <= 1'b0;
                        cnt_r       <= per_r - BAUD_W'(1);
                        tx_done_r   <= per_one_s;
                    end else if (pop_s) begin
                        // Next word already queued: start bit follows directly.
                        shift_r      <= fifo_rdata_s;
                        per_r        <= eff_period_s;
                        nbits_r      <= eff_bits_s;
                        par_en_r     <= (mode_s != PAR_NONE);
                        par_bit_r    <= head_par_s;
                        two_stop_r   <= two_stop;
                        cnt_r        <= eff_period_s - BAUD_W'(1);
                        serial_out_r <= 1'b0;
                        state_r      <= START;
                    end else begin
                        serial_out_r <= 1'b1;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    serial_out_r <= 1'b1;
                    cnt_r        <= BAUD_W'(0);
                    state_r      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_stream
// Directed bench for uart_tx_stream: reset/idle, 8N1 timing, parity and
// framing options (including clamped data_bits and zero bit_period), FIFO
// full back-pressure, back-to-back streaming and reset during a frame.
// -----------------------------------------------------------------------------
module tb_uart_tx_stream;

    logic        clk = 1'b0;
    logic        nrst;
    logic [15:0] bit_period;
    logic [3:0]  data_bits;
    logic [1:0]  parity_mode;
    logic        two_stop;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        serial_out;
    logic        busy;
    logic        tx_done;
    logic [4:0]  fifo_count;

    int total = 0;
    int bad   = 0;

    // Per-cycle record of one frame, index 1 = first start-bit cycle
    logic line_a [0:511];
    logic tx_a   [0:511];
    // Expected bit sequence of one frame (start .. last stop)
    logic exp_a  [0:15];
    int   exp_n;

    uart_tx_stream #(
        .DATA_W     (8),
        .FIFO_DEPTH (16),
        .BAUD_W     (16),
        .CNT_W      (5)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .bit_period  (bit_period),
        .data_bits   (data_bits),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .serial_out  (serial_out),
        .busy        (busy),
        .tx_done     (tx_done),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    // Expected line bits: start, nb data bits LSB first, optional parity, stops.
    task automatic build_frame(input logic [7:0] d, input int nb, input int pm, input bit ts);
        logic p;
        exp_n = 0;
        exp_a[exp_n] = 1'b0; exp_n++;
        p = 1'b0;
        for (int i = 0; i < nb; i++) begin
            exp_a[exp_n] = d[i]; exp_n++;
            p = p ^ d[i];
        end
        if (pm == 1) begin
            exp_a[exp_n] = p; exp_n++;
        end else if (pm == 2) begin
            exp_a[exp_n] = ~p; exp_n++;
        end
        exp_a[exp_n] = 1'b1; exp_n++;
        if (ts) begin
            exp_a[exp_n] = 1'b1; exp_n++;
        end
    endtask

    task automatic set_cfg(input int per, input int nb, input int pm, input bit ts);
        bit_period  = 16'(per);
        data_bits   = 4'(nb);
        parity_mode = 2'(pm);
        two_stop    = ts;
    endtask

    // One accepted write; starts and ends 1 time unit after a rising edge.
    task automatic push_word(input logic [7:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for a start bit, then records the line until tx_done.
    // wait_cyc counts cycles sampled before the start bit; done_cyc = 0 on timeout.
    task automatic capture_frame(output int wait_cyc, output int done_cyc);
        int k;
        wait_cyc = 0;
        done_cyc = 0;
        @(posedge clk); #1;
        while (serial_out !== 1'b0 && wait_cyc < 3000) begin
            wait_cyc++;
            @(posedge clk); #1;
        end
        k = 1;
        while (k <= 500 && done_cyc == 0) begin
            line_a[k] = serial_out;
            tx_a[k]   = tx_done;
            if (tx_done === 1'b1) begin
                done_cyc = k;
            end else begin
                @(posedge clk); #1;
                k++;
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        set_cfg(4, 8, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({serial_out, in_ready, busy, tx_done, fifo_count} !== {1'b1, 1'b1, 1'b0, 1'b0, 5'd0}) begin
            bad++;
            $display("FAIL reset_held: got so/rdy/busy/done/cnt=%b want 1_1_0_0_00000",
                     {serial_out, in_ready, busy, tx_done, fifo_count});
        end
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 100; c++) begin
            total++;
            if ({serial_out, in_ready, busy, tx_done, fifo_count} !== {1'b1, 1'b1, 1'b0, 1'b0, 5'd0}) begin
                bad++;
                $display("FAIL idle_after_reset cyc %0d: got so/rdy/busy/done/cnt=%b want 1_1_0_0_00000",
                         c, {serial_out, in_ready, busy, tx_done, fifo_count});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_basic_8n1();
        int w, d;
        logic [9:0] exp_bits;
        exp_bits = 10'b1010101010;   // bit0 = start, bits1..8 = 0x55 LSB first, bit9 = stop
        set_cfg(4, 8, 0, 1'b0);
        push_word(8'h55);
        capture_frame(w, d);
        total++;
        if (w !== 0) begin bad++; $display("FAIL 8n1_start_latency: got %0d want 0", w); end
        total++;
        if (d !== 40) begin bad++; $display("FAIL 8n1_done_cycle: got %0d want 40", d); end
        for (int k = 1; k <= 40; k++) begin
            total++;
            if (line_a[k] !== exp_bits[(k - 1) / 4]) begin
                bad++;
                $display("FAIL 8n1_line cyc %0d: got %b want %b", k, line_a[k], exp_bits[(k - 1) / 4]);
            end
            total++;
            if (tx_a[k] !== (k == 40)) begin
                bad++;
                $display("FAIL 8n1_tx_done cyc %0d: got %b want %b", k, tx_a[k], (k == 40));
            end
        end
        @(posedge clk); #1;
        total++;
        if ({busy, tx_done, serial_out} !== 3'b001) begin
            bad++;
            $display("FAIL 8n1_after_frame: got busy/done/so=%b want 001", {busy, tx_done, serial_out});
        end
    endtask

    task automatic test_parity();
        int w, d;
        // Frame A: 0x07, 7 bits, even, two stop, period 3; config flips to odd mid-frame.
        set_cfg(3, 7, 1, 1'b1);
        push_word(8'h07);
        fork
            capture_frame(w, d);
            begin
                repeat (5) @(posedge clk);
                #2 parity_mode = 2'b10;
            end
        join
        total++;
        if (d !== 33) begin bad++; $display("FAIL par_even_len: got %0d want 33", d); end
        total++;
        if (line_a[26] !== 1'b1) begin bad++; $display("FAIL par_even_bit: got %b want 1", line_a[26]); end
        build_frame(8'h07, 7, 1, 1'b1);
        for (int k = 1; k <= 33; k++) begin
            total++;
            if (line_a[k] !== exp_a[(k - 1) / 3]) begin
                bad++;
                $display("FAIL par_even_line cyc %0d: got %b want %b", k, line_a[k], exp_a[(k - 1) / 3]);
            end
        end
        // Frame B: same word, odd parity now latched.
        push_word(8'h07);
        capture_frame(w, d);
        total++;
        if (d !== 33) begin bad++; $display("FAIL par_odd_len: got %0d want 33", d); end
        total++;
        if (line_a[26] !== 1'b0) begin bad++; $display("FAIL par_odd_bit: got %b want 0", line_a[26]); end
        // Frame C: period 0 acts as 1, data_bits 2 clamps to 8, even, one stop -> 11 cycles.
        set_cfg(0, 2, 1, 1'b0);
        push_word(8'h07);
        capture_frame(w, d);
        total++;
        if (d !== 11) begin bad++; $display("FAIL clamp_len: got %0d want 11", d); end
        build_frame(8'h07, 8, 1, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            total++;
            if (line_a[k] !== exp_a[k - 1]) begin
                bad++;
                $display("FAIL clamp_line cyc %0d: got %b want %b", k, line_a[k], exp_a[k - 1]);
            end
        end
        // Frame D: minimum 5 bits, mode 11 means no parity, period 2 -> 14 cycles.
        set_cfg(2, 5, 3, 1'b0);
        push_word(8'hFF);
        capture_frame(w, d);
        total++;
        if (d !== 14) begin bad++; $display("FAIL min_bits_len: got %0d want 14", d); end
        build_frame(8'hFF, 5, 0, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            total++;
            if (line_a[k] !== exp_a[(k - 1) / 2]) begin
                bad++;
                $display("FAIL min_bits_line cyc %0d: got %b want %b", k, line_a[k], exp_a[(k - 1) / 2]);
            end
        end
    endtask

    task automatic test_full_fifo();
        int   idx, cyc, dones, acc_cyc, cyc2;
        logic rdy_pre;
        set_cfg(10, 8, 0, 1'b0);
        idx = 0; cyc = 0; dones = 0; acc_cyc = -1;
        while (idx < 18 && cyc < 400) begin
            in_data  = 8'(8'hA0 + idx);
            in_valid = 1'b1;
            rdy_pre  = in_ready;
            @(posedge clk); #1;
            if (rdy_pre) idx++;
            if (tx_done === 1'b1) dones++;
            if (cyc == 1) begin
                total++;
                if (serial_out !== 1'b0) begin
                    bad++; $display("FAIL full_first_start: got %b want 0", serial_out);
                end
            end
            if (rdy_pre && idx == 17) begin
                total++;
                if (fifo_count !== 5'd16) begin
                    bad++; $display("FAIL full_count: got %0d want 16", fifo_count);
                end
                total++;
                if (in_ready !== 1'b0) begin
                    bad++; $display("FAIL full_ready: got %b want 0", in_ready);
                end
            end
            if (rdy_pre && idx == 18) acc_cyc = cyc;
            cyc++;
        end
        in_valid = 1'b0;
        total++;
        if (acc_cyc !== 102) begin bad++; $display("FAIL full_18th_accept: got %0d want 102", acc_cyc); end
        total++;
        if (dones !== 1) begin bad++; $display("FAIL full_done_before_18th: got %0d want 1", dones); end
        cyc2 = 0;
        while (busy === 1'b1 && cyc2 < 3000) begin
            @(posedge clk); #1;
            if (tx_done === 1'b1) dones++;
            cyc2++;
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL full_drain_busy: got %b want 0", busy); end
        total++;
        if (dones !== 18) begin bad++; $display("FAIL full_drain_dones: got %0d want 18", dones); end
    endtask

    task automatic test_back_to_back();
        int         w, d, nd;
        logic [7:0] words [3];
        logic [7:0] got;
        words[0] = 8'h3C; words[1] = 8'hA5; words[2] = 8'h81;
        set_cfg(2, 8, 0, 1'b0);
        push_word(words[0]);
        nd = 0;
        for (int f = 0; f < 3; f++) begin
            if (f == 0) begin
                fork
                    capture_frame(w, d);
                    begin
                        push_word(words[1]);
                        push_word(words[2]);
                    end
                join
            end else begin
                capture_frame(w, d);
            end
            got = 8'h00;
            for (int i = 0; i < 8; i++) got[i] = line_a[(1 + i) * 2 + 1];
            for (int k = 1; k <= 20; k++) if (tx_a[k] === 1'b1) nd++;
            total++;
            if (w !== 0) begin bad++; $display("FAIL b2b_gap frame %0d: got %0d want 0", f, w); end
            total++;
            if (d !== 20) begin bad++; $display("FAIL b2b_len frame %0d: got %0d want 20", f, d); end
            total++;
            if (got !== words[f]) begin
                bad++; $display("FAIL b2b_data frame %0d: got %h want %h", f, got, words[f]);
            end
        end
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (tx_done === 1'b1) nd++;
        end
        total++;
        if (nd !== 3) begin bad++; $display("FAIL b2b_done_count: got %0d want 3", nd); end
        total++;
        if ({busy, serial_out} !== 2'b01) begin
            bad++; $display("FAIL b2b_idle: got busy/so=%b want 01", {busy, serial_out});
        end
    endtask

    task automatic test_reset_mid_frame();
        int w, d, nd;
        set_cfg(4, 8, 0, 1'b0);
        push_word(8'h00);
        push_word(8'h11);            // now in frame cycle 1, one word queued
        repeat (17) @(posedge clk);
        #1;                          // frame cycle 18: data bit 3
        total++;
        if ({serial_out, fifo_count} !== {1'b0, 5'd1}) begin
            bad++; $display("FAIL midrst_before: got so/cnt=%b want 0_00001", {serial_out, fifo_count});
        end
        #2 nrst = 1'b0;
        #1;
        total++;
        if ({serial_out, in_ready, busy, tx_done, fifo_count} !== {1'b1, 1'b1, 1'b0, 1'b0, 5'd0}) begin
            bad++;
            $display("FAIL midrst_during: got so/rdy/busy/done/cnt=%b want 1_1_0_0_00000",
                     {serial_out, in_ready, busy, tx_done, fifo_count});
        end
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
        nd = 0;
        for (int c = 0; c < 50; c++) begin
            if (tx_done === 1'b1 || serial_out !== 1'b1) nd++;
            @(posedge clk); #1;
        end
        total++;
        if (nd !== 0) begin bad++; $display("FAIL midrst_quiet: got %0d active cycles want 0", nd); end
        push_word(8'h96);
        capture_frame(w, d);
        total++;
        if (d !== 40) begin bad++; $display("FAIL midrst_fresh_len: got %0d want 40", d); end
        build_frame(8'h96, 8, 0, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            total++;
            if (line_a[k] !== exp_a[(k - 1) / 4]) begin
                bad++;
                $display("FAIL midrst_fresh_line cyc %0d: got %b want %b", k, line_a[k], exp_a[(k - 1) / 4]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_parity();
        test_full_fifo();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
